// File: rtl/capture_pkg.sv
//------------------------------------------------------------------------------
// Module  : capture_pkg
// Brief   : Shared state encoding and default widths for the capture sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package capture_pkg;

    localparam int unsigned c_DATA_SIZE = 12;
    localparam int unsigned c_LEN_W     = 9;
    localparam int unsigned c_DECIM_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/trig_detect.sv
//------------------------------------------------------------------------------
// Module  : trig_detect
// Brief   : Level-crossing edge detector on a strobed sample stream.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module trig_detect
    import capture_pkg::*;
#(
    parameter int unsigned DATA_SIZE = c_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_accept,
    input  logic [DATA_SIZE-1:0] i_sample,
    input  logic [DATA_SIZE-1:0] i_level,
    input  logic                 i_rising,
    output logic                 o_hit
);

    logic [DATA_SIZE-1:0] r_prev;
    logic                 r_prev_valid;
    logic                 w_rise;
    logic                 w_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
        end else if (i_clear) begin
            r_prev_valid <= 1'b0;
        end else if (i_accept) begin
            r_prev       <= i_sample;
            r_prev_valid <= 1'b1;
        end
    end

    assign w_rise = (r_prev < i_level) && (i_sample >= i_level);
    assign w_fall = (r_prev > i_level) && (i_sample <= i_level);

    // No edge can be claimed until one earlier sample has been seen.
    assign o_hit = i_accept && r_prev_valid && (i_rising ? w_rise : w_fall);

endmodule

`default_nettype wire

// File: rtl/capture_ctrl.sv
//------------------------------------------------------------------------------
// Module  : capture_ctrl
// Brief   : Write-side capture sequencer: decimate, trigger, fill sample FIFO.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module capture_ctrl
    import capture_pkg::*;
#(
    parameter int unsigned DATA_SIZE = c_DATA_SIZE,
    parameter int unsigned LEN_W     = c_LEN_W,
    parameter int unsigned DECIM_W   = c_DECIM_W
) (
    input  logic                 w_clk_i,
    input  logic                 w_rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 force_trig_i,
    input  logic [DATA_SIZE-1:0] trig_level_i,
    input  logic                 trig_rising_i,
    input  logic [DECIM_W-1:0]   decim_i,
    input  logic [LEN_W-1:0]     capture_len_i,
    input  logic                 sample_valid_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic                 fifo_full_i,
    output logic                 fifo_inc_o,
    output logic [DATA_SIZE-1:0] fifo_data_o,
    output logic                 busy_o,
    output logic                 triggered_o,
    output logic                 done_o,
    output logic                 overflow_o
);

    cap_state_t           r_state;
    cap_state_t           w_state_nxt;

    logic [DATA_SIZE-1:0] r_level;
    logic                 r_rising;
    logic [DECIM_W-1:0]   r_decim;
    logic [LEN_W-1:0]     r_len;
    logic [DECIM_W-1:0]   r_dec_cnt;
    logic [LEN_W-1:0]     r_wr_cnt;
    logic                 r_wr_pend;
    logic [DATA_SIZE-1:0] r_wr_data;
    logic                 r_triggered;
    logic                 r_overflow;
    logic                 r_force_pend;

    logic                 w_armed;
    logic                 w_capture;
    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_hit;
    logic                 w_trig;
    logic                 w_fifo_inc;
    logic                 w_last_wr;
    logic                 w_load;

    assign w_armed    = (r_state == ST_ARMED);
    assign w_capture  = (r_state == ST_CAPTURE);
    assign w_start_ok = start_i && !abort_i && (capture_len_i != '0) &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_accept   = (w_armed || w_capture) && sample_valid_i && (r_dec_cnt == '0);
    assign w_trig     = w_armed && w_accept && (r_force_pend || w_hit);
    assign w_fifo_inc = r_wr_pend && !fifo_full_i;
    assign w_last_wr  = w_fifo_inc && (r_wr_cnt == r_len - 1'b1);
    // The sample accepted alongside the final write is never staged.
    assign w_load     = w_trig || (w_capture && w_accept && !w_last_wr);

    trig_detect #(
        .DATA_SIZE (DATA_SIZE)
    ) u_trig_detect (
        .clk      (w_clk_i),
        .rst      (w_rst_i),
        .i_clear  (w_start_ok || abort_i),
        .i_accept (w_armed && w_accept),
        .i_sample (sample_i),
        .i_level  (r_level),
        .i_rising (r_rising),
        .o_hit    (w_hit)
    );

    always_ff @(posedge w_clk_i or posedge w_rst_i) begin
        if (w_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (w_start_ok) w_state_nxt = ST_ARMED;
                ST_ARMED:         if (w_trig)     w_state_nxt = ST_CAPTURE;
                ST_CAPTURE:       if (w_last_wr)  w_state_nxt = ST_DONE;
                default:                          w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge w_clk_i or posedge w_rst_i) begin
        if (w_rst_i) begin
            r_level      <= '0;
            r_rising     <= 1'b0;
            r_decim      <= '0;
            r_len        <= '0;
            r_dec_cnt    <= '0;
            r_wr_cnt     <= '0;
            r_wr_pend    <= 1'b0;
            r_wr_data    <= '0;
            r_triggered  <= 1'b0;
            r_overflow   <= 1'b0;
            r_force_pend <= 1'b0;
        end else begin
            r_wr_pend <= 1'b0;
            if (abort_i) begin
                r_triggered  <= 1'b0;
                r_overflow   <= 1'b0;
                r_force_pend <= 1'b0;
            end else if (w_start_ok) begin
                r_level      <= trig_level_i;
                r_rising     <= trig_rising_i;
                r_decim      <= decim_i;
                r_len        <= capture_len_i;
                r_dec_cnt    <= '0;
                r_wr_cnt     <= '0;
                r_triggered  <= 1'b0;
                r_overflow   <= 1'b0;
                r_force_pend <= 1'b0;
            end else begin
                if ((w_armed || w_capture) && sample_valid_i) begin
                    r_dec_cnt <= (r_dec_cnt == '0) ? r_decim : r_dec_cnt - 1'b1;
                end
                if (w_armed && force_trig_i) begin
                    r_force_pend <= 1'b1;
                end
                if (w_trig) begin
                    r_force_pend <= 1'b0;
                    r_triggered  <= 1'b1;
                end
                if (w_load) begin
                    r_wr_pend <= 1'b1;
                    r_wr_data <= sample_i;
                end
                if (r_wr_pend && fifo_full_i) begin
                    r_overflow <= 1'b1;
                end
                if (w_fifo_inc) begin
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
            end
        end
    end

    assign fifo_inc_o  = w_fifo_inc;
    assign fifo_data_o = r_wr_data;
    assign busy_o      = w_armed || w_capture;
    assign done_o      = (r_state == ST_DONE);
    assign triggered_o = r_triggered;
    assign overflow_o  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_capture_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_capture_ctrl
// Brief   : Self-checking bench for capture_ctrl with a write-data scoreboard.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_capture_ctrl;

    localparam int DS = 12;
    localparam int LW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          force_trig = 1'b0;
    logic [DS-1:0] level = '0;
    logic          rising = 1'b0;
    logic [DW-1:0] decim = '0;
    logic [LW-1:0] len = '0;
    logic          valid = 1'b0;
    logic [DS-1:0] sample = '0;
    logic          full = 1'b0;

    logic          fifo_inc;
    logic [DS-1:0] fifo_data;
    logic          busy;
    logic          triggered;
    logic          done;
    logic          overflow;

    int            tests_run = 0;
    int            failed = 0;
    int            n_wr = 0;
    int            cyc = 0;
    int            last_inc_cyc = -1;
    int            done_rise_cyc = -1;
    logic          prev_done = 1'b0;
    logic [DS-1:0] exp_q[$];

    capture_ctrl #(
        .DATA_SIZE (DS),
        .LEN_W     (LW),
        .DECIM_W   (DW)
    ) dut (
        .w_clk_i        (clk),
        .w_rst_i        (rst),
        .start_i        (start),
        .abort_i        (abort),
        .force_trig_i   (force_trig),
        .trig_level_i   (level),
        .trig_rising_i  (rising),
        .decim_i        (decim),
        .capture_len_i  (len),
        .sample_valid_i (valid),
        .sample_i       (sample),
        .fifo_full_i    (full),
        .fifo_inc_o     (fifo_inc),
        .fifo_data_o    (fifo_data),
        .busy_o         (busy),
        .triggered_o    (triggered),
        .done_o         (done),
        .overflow_o     (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard: every FIFO write must match the oldest expected sample.
    always @(negedge clk) begin
        if (!rst && fifo_inc) begin
            n_wr++;
            last_inc_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_write got %0d, required no write", fifo_data);
            end else begin
                logic [DS-1:0] e;
                e = exp_q.pop_front();
                if (fifo_data !== e) begin
                    failed++;
                    $display("FAIL write_data got %0d, required %0d", fifo_data, e);
                end
            end
        end
        if (done && !prev_done) done_rise_cyc = cyc;
        prev_done = done;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input int lvl, input logic rise, input int dec, input int ln);
        level  = DS'(lvl);
        rising = rise;
        decim  = DW'(dec);
        len    = LW'(ln);
        start  = 1'b1;
        step();
        start  = 1'b0;
        n_wr   = 0;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        for (int k = 0; k < max_cycles && !done; k++) step();
        tests_run++;
        if (done !== 1'b1) begin
            failed++;
            $display("FAIL %s_done_timeout got done=%0b, required 1", tag, done);
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({fifo_inc, busy, triggered, done, overflow} !== 5'b0 || fifo_data !== '0) begin
            failed++;
            $display("FAIL reset_outputs got %b/%0d, required 00000/0",
                     {fifo_inc, busy, triggered, done, overflow}, fifo_data);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle got busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    task automatic test_rising();
        exp_q.push_back(DS'(100)); exp_q.push_back(DS'(105));
        exp_q.push_back(DS'(110)); exp_q.push_back(DS'(115));
        arm(100, 1'b1, 0, 4);
        tests_run++;
        if (busy !== 1'b1) begin
            failed++;
            $display("FAIL rise_armed_busy got %0b, required 1", busy);
        end
        for (int i = 0; i < 9; i++) begin
            valid  = 1'b1;
            sample = DS'(90 + 5 * i);
            step();
        end
        valid = 1'b0;
        wait_done(20, "rise");
        tests_run++;
        if (n_wr !== 4) begin
            failed++;
            $display("FAIL rise_count got %0d, required 4", n_wr);
        end
        tests_run++;
        if (done_rise_cyc !== last_inc_cyc + 1) begin
            failed++;
            $display("FAIL rise_done_latency got cycle %0d, required %0d", done_rise_cyc, last_inc_cyc + 1);
        end
        tests_run++;
        if (triggered !== 1'b1 || overflow !== 1'b0 || busy !== 1'b0) begin
            failed++;
            $display("FAIL rise_flags got trig=%0b ovf=%0b busy=%0b, required 1 0 0", triggered, overflow, busy);
        end
    endtask

    task automatic test_falling_decim();
        exp_q.push_back(DS'(50)); exp_q.push_back(DS'(20)); exp_q.push_back(DS'(0));
        arm(50, 1'b0, 2, 3);
        for (int i = 0; i < 15; i++) begin
            valid  = 1'b1;
            sample = (i < 9) ? DS'(80 - 10 * i) : DS'(0);
            step();
        end
        valid = 1'b0;
        wait_done(20, "fall");
        tests_run++;
        if (n_wr !== 3 || exp_q.size() != 0) begin
            failed++;
            $display("FAIL fall_count got %0d writes (%0d unmatched), required 3 (0)", n_wr, exp_q.size());
        end
        tests_run++;
        if (triggered !== 1'b1) begin
            failed++;
            $display("FAIL fall_triggered got %0b, required 1", triggered);
        end
    endtask

    task automatic test_force();
        exp_q.push_back(DS'(7)); exp_q.push_back(DS'(7));
        arm(100, 1'b1, 0, 2);
        for (int i = 0; i < 4; i++) begin
            valid  = 1'b1;
            sample = DS'(7);
            step();
        end
        valid = 1'b0;
        tests_run++;
        if (triggered !== 1'b0 || n_wr !== 0) begin
            failed++;
            $display("FAIL force_pre got trig=%0b writes=%0d, required 0 0", triggered, n_wr);
        end
        force_trig = 1'b1;
        step();
        force_trig = 1'b0;
        for (int i = 0; i < 6; i++) begin
            valid  = 1'b1;
            sample = DS'(7);
            step();
        end
        valid = 1'b0;
        wait_done(20, "force");
        tests_run++;
        if (n_wr !== 2 || triggered !== 1'b1) begin
            failed++;
            $display("FAIL force_result got writes=%0d trig=%0b, required 2 1", n_wr, triggered);
        end
    endtask

    task automatic test_fifo_full();
        exp_q.push_back(DS'(100)); exp_q.push_back(DS'(105));
        exp_q.push_back(DS'(125)); exp_q.push_back(DS'(130)); exp_q.push_back(DS'(135));
        arm(100, 1'b1, 0, 5);
        for (int i = 0; i < 14; i++) begin
            valid  = 1'b1;
            sample = DS'(90 + 5 * i);
            full   = (i >= 5 && i <= 7);
            step();
        end
        valid = 1'b0;
        full  = 1'b0;
        wait_done(20, "full");
        tests_run++;
        if (n_wr !== 5 || exp_q.size() != 0) begin
            failed++;
            $display("FAIL full_count got %0d writes (%0d unmatched), required 5 (0)", n_wr, exp_q.size());
        end
        tests_run++;
        if (overflow !== 1'b1) begin
            failed++;
            $display("FAIL full_overflow got %0b, required 1", overflow);
        end
    endtask

    task automatic test_abort();
        exp_q.push_back(DS'(100)); exp_q.push_back(DS'(105));
        arm(100, 1'b1, 0, 8);
        for (int i = 0; i < 5; i++) begin
            valid  = 1'b1;
            sample = DS'(90 + 5 * i);
            abort  = (i == 4);
            step();
        end
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || triggered !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL abort_idle got busy=%0b trig=%0b done=%0b ovf=%0b, required 0 0 0 0",
                     busy, triggered, done, overflow);
        end
        for (int i = 0; i < 3; i++) begin
            sample = DS'(120 + 5 * i);
            @(negedge clk);
            tests_run++;
            if (fifo_inc !== 1'b0) begin
                failed++;
                $display("FAIL abort_no_write got fifo_inc=%0b, required 0", fifo_inc);
            end
            step();
        end
        valid = 1'b0;
        tests_run++;
        if (n_wr !== 2) begin
            failed++;
            $display("FAIL abort_count got %0d, required 2", n_wr);
        end
        exp_q.push_back(DS'(100)); exp_q.push_back(DS'(105));
        arm(100, 1'b1, 0, 2);
        for (int i = 0; i < 9; i++) begin
            valid  = 1'b1;
            sample = DS'(90 + 5 * i);
            step();
        end
        valid = 1'b0;
        wait_done(20, "rearm");
        tests_run++;
        if (n_wr !== 2 || triggered !== 1'b1) begin
            failed++;
            $display("FAIL rearm_result got writes=%0d trig=%0b, required 2 1", n_wr, triggered);
        end
    endtask

    task automatic test_async_reset();
        bit hit_reset;
        hit_reset = 1'b0;
        exp_q.push_back(DS'(100));
        arm(100, 1'b1, 0, 8);
        for (int i = 0; i < 6 && !hit_reset; i++) begin
            valid  = 1'b1;
            sample = DS'(90 + 5 * i);
            full   = (i == 4);
            if (i == 5) begin
                tests_run++;
                if (overflow !== 1'b1 || busy !== 1'b1) begin
                    failed++;
                    $display("FAIL prereset_state got ovf=%0b busy=%0b, required 1 1", overflow, busy);
                end
                #2;
                rst = 1'b1;
                #1;
                tests_run++;
                if ({fifo_inc, busy, triggered, done, overflow} !== 5'b0 || fifo_data !== '0) begin
                    failed++;
                    $display("FAIL async_reset got %b/%0d, required 00000/0",
                             {fifo_inc, busy, triggered, done, overflow}, fifo_data);
                end
                hit_reset = 1'b1;
            end else begin
                step();
            end
        end
        valid = 1'b0;
        full  = 1'b0;
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if (n_wr !== 1 || exp_q.size() != 0) begin
            failed++;
            $display("FAIL reset_writes got %0d (%0d unmatched), required 1 (0)", n_wr, exp_q.size());
        end
        level = DS'(100);
        len   = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL zero_len_start got busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_rising();
        test_falling_decim();
        test_force();
        test_fifo_full();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #200000;
        failed++;
        $display("FAIL global_timeout got no completion, required finish");
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Write-side sequencer for the sample FIFO. It sits in the FIFO write clock domain between the ADC sample stream and the FIFO write port.
- Once armed, it decimates the stream and waits for a level/edge trigger (or a forced trigger).
- It then writes exactly capture_len decimated samples into the FIFO, reports completion, and flags any sample lost to FIFO-full.

Parameters:
DATA_SIZE, 12, sample width (matches FIFO data width)
LEN_W, 9, width of capture length / write counter
DECIM_W, 8, width of decimation ratio

Ports:
w_clk_i  in  1  clock (FIFO write clock)
w_rst_i  in  1  asynchronous reset, active-high
start_i  in  1  pulse: arm (from IDLE or DONE); latches configuration
abort_i  in  1  pulse: return to IDLE from any state; priority over start_i
force_trig_i  in  1  pulse: treat next accepted sample as trigger (ARMED only)
trig_level_i  in  DATA_SIZE  trigger threshold, unsigned
trig_rising_i  in  1  1 = rising-edge trigger, 0 = falling-edge trigger
decim_i  in  DECIM_W  keep 1 of (decim_i+1) valid samples
capture_len_i  in  LEN_W  samples to write per capture; 0 = start ignored
sample_valid_i  in  1  ADC sample strobe
sample_i  in  DATA_SIZE  ADC sample
fifo_full_i  in  1  FIFO full flag (write domain)
fifo_inc_o  out  1  FIFO write enable
fifo_data_o  out  DATA_SIZE  FIFO write data
busy_o  out  1  state is ARMED or CAPTURE
triggered_o  out  1  trigger seen in current capture (sticky until start/abort)
done_o  out  1  state is DONE
overflow_o  out  1  sticky: a capture sample was dropped because FIFO was full

Behaviour:
- Reset (async, w_rst_i=1):
  - state IDLE; all outputs 0; counters and prev_valid cleared.
- Configuration latch:
  - A start_i accepted in IDLE or DONE with capture_len_i!=0 latches trig_level_i, trig_rising_i, decim_i and capture_len_i.
  - Accepted start_i clears triggered_o and overflow_o, zeroes the decimation and write counters, clears prev_valid, and enters ARMED.
  - start_i with capture_len_i==0 is ignored.
  - start_i in ARMED or CAPTURE is ignored.
- Decimation:
  - A sample is accepted when sample_valid_i=1 and the decimation counter is 0; the counter then loads the latched decim.
  - On other valid samples the counter decrements.
  - decim=0 accepts every valid sample.
- Trigger detection: only on accepted samples; prev = last accepted sample; comparison is unsigned.
  - Rising: prev < level && cur >= level.
  - Falling: prev > level && cur <= level.
  - The first accepted sample after arming has no prev (prev_valid=0) and cannot edge-trigger.
- Force trigger: force_trig_i in ARMED sets force_pend. The next accepted sample triggers regardless of level. force_pend is cleared on trigger or abort.
- States: IDLE -> ARMED -> CAPTURE -> DONE.
  - ARMED: an accepted sample that triggers sets triggered_o and becomes the first capture sample. Go to CAPTURE.
  - CAPTURE: every accepted sample (including the trigger sample) loads a 1-deep write stage: wr_pend=1, fifo_data_o=sample, valid the cycle after acceptance.
- FIFO write issue:
  - fifo_inc_o = wr_pend & ~fifo_full_i. This is qualified in the issue cycle, so the full flag is never stale.
  - If wr_pend and fifo_full_i: the sample is dropped, overflow_o is set, and the write counter does not advance. The capture continues and ends after capture_len successful writes.
  - Latency: sample_valid_i (accepted) at cycle n -> fifo_inc_o at cycle n+1.
  - wr_pend clears after one cycle, whether the sample was written or dropped.
- Write counter: increments on each fifo_inc_o.
  - When the count reaches len, go to DONE on the following edge. Accepted samples in that cycle are not written.
  - Counting never exceeds len.
- DONE: done_o=1. start_i re-arms. abort_i -> IDLE.
- Abort: abort_i in any state -> IDLE next edge.
  - Squashes wr_pend: no fifo_inc_o in the cycle after abort.
  - Clears triggered_o, overflow_o and force_pend.
  - Abort mid-CAPTURE leaves already-written samples in the FIFO; draining them is the reader's concern.
- Outputs busy_o and done_o are decoded from the registered state, with no combinational path from inputs. fifo_inc_o is the only output with a combinational input (fifo_full_i).

Decomposition:
- Package capture_pkg holds:
  - the state enum (IDLE, ARMED, CAPTURE, DONE), 2 bits;
  - default widths DATA_SIZE/LEN_W/DECIM_W.
- One sub-module, trig_detect:
  - holds the prev register and prev_valid;
  - inputs: accept strobe, sample, level, rising, clear;
  - output: 1-bit trig hit;
  - reused later for the display trigger.

Test Plan:
- Rising trigger: level=100, decim=0, len=4, ramp 90,95,...,130 every cycle. Sample 100 triggers; FIFO receives 100,105,110,115. done_o rises 1 cycle after the 4th fifo_inc_o. triggered_o=1, overflow_o=0.
- Falling plus decimation: level=50, rising=0, decim=2, len=3. Samples 80,70,...,0 valid every cycle; accepted are 80,50,20 (every 3rd). 50 triggers; FIFO gets 50,20,then next accepted.
- Forced trigger: flat input 7, level=100, pulse force_trig_i. Next accepted sample (7) is written. len=2 -> two writes of 7, then DONE.
- FIFO full: hold fifo_full_i=1 for 3 cycles mid-capture with len=5. Exactly 5 fifo_inc_o pulses total, overflow_o=1, and the dropped samples are absent from the data.
- Abort mid-capture at write 2 of len=8 with wr_pend set: no further fifo_inc_o, IDLE next cycle, busy_o/triggered_o=0. start_i then re-arms cleanly.
- Async reset asserted mid-CAPTURE, between clock edges: all outputs 0 immediately. start_i with len=0 after reset keeps IDLE (busy_o=0).
